// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display/status outputs of the stopwatch controller.
// The master side drives the buttons. The slave side presents the display and status signals.
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] sec_lo;
  logic [3:0] sec_hi;
  logic [3:0] min;
  logic       running;
  logic       frozen;
  logic       tick;
  logic       overflow;

  modport master (
    output start_stop, lap, clear,
    input  sec_lo, sec_hi, min, running, frozen, tick, overflow
  );

  modport slave (
    input  start_stop, lap, clear,
    output sec_lo, sec_hi, min, running, frozen, tick, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// BCD stopwatch with run/pause, lap freeze and clear.
// The buttons are synchronized and edge-detected. A prescaler produces one tick per TICK_DIV cycles.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int MIN_MAX  = 9
) (
  input  logic            clk,
  input  logic            aclr,
  stopwatch_ctrl_if.slave bus
);

  localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]     MIN_LAST   = 4'(MIN_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, HOLD} state_t;

  state_t        state_reg, state_next;
  logic          latch_en;
  logic [2:0]    btn_level;
  logic [2:0]    btn_edge;
  logic          ss_edge, lap_edge, clr_edge;
  logic          counting, tick_int;
  logic [PW-1:0] presc_reg;
  logic [3:0]    sec_lo_reg, sec_hi_reg, min_reg;
  logic [3:0]    held_lo_reg, held_hi_reg, held_min_reg;
  logic          overflow_reg;

  assign btn_level = {bus.clear, bus.lap, bus.start_stop};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic sync1_reg, sync2_reg, sync3_reg;
      always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          sync3_reg <= 1'b0;
        end else begin
          sync1_reg <= btn_level[gi];
          sync2_reg <= sync1_reg;
          sync3_reg <= sync2_reg;
        end
      end
      assign btn_edge[gi] = sync2_reg & ~sync3_reg;
    end
  endgenerate

  assign ss_edge  = btn_edge[0];
  assign lap_edge = btn_edge[1];
  assign clr_edge = btn_edge[2];

  assign counting = (state_reg == RUN) || (state_reg == HOLD);
  assign tick_int = counting && (presc_reg == PRESC_LAST);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // clear beats start_stop beats lap. A losing edge is simply dropped.
  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    if (clr_edge) begin
      state_next = IDLE;
    end else if (ss_edge) begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        HOLD:    state_next = PAUSE;
        default: state_next = IDLE;
      endcase
    end else if (lap_edge) begin
      if (state_reg == RUN) begin
        state_next = HOLD;
        latch_en   = 1'b1;
      end else if (state_reg == HOLD) begin
        state_next = RUN;
      end
    end
  end

  // Latching uses the pre-edge digits, so a coincident tick is not captured.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      presc_reg    <= '0;
      sec_lo_reg   <= '0;
      sec_hi_reg   <= '0;
      min_reg      <= '0;
      held_lo_reg  <= '0;
      held_hi_reg  <= '0;
      held_min_reg <= '0;
      overflow_reg <= 1'b0;
    end else if (clr_edge) begin
      presc_reg    <= '0;
      sec_lo_reg   <= '0;
      sec_hi_reg   <= '0;
      min_reg      <= '0;
      held_lo_reg  <= '0;
      held_hi_reg  <= '0;
      held_min_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (counting) presc_reg <= tick_int ? '0 : presc_reg + PW'(1);
      if (tick_int) begin
        if (sec_lo_reg == 4'd9) begin
          sec_lo_reg <= 4'd0;
          if (sec_hi_reg == 4'd5) begin
            sec_hi_reg <= 4'd0;
            if (min_reg == MIN_LAST) begin
              min_reg      <= 4'd0;
              overflow_reg <= 1'b1;
            end else begin
              min_reg <= min_reg + 4'd1;
            end
          end else begin
            sec_hi_reg <= sec_hi_reg + 4'd1;
          end
        end else begin
          sec_lo_reg <= sec_lo_reg + 4'd1;
        end
      end
      if (latch_en) begin
        held_lo_reg  <= sec_lo_reg;
        held_hi_reg  <= sec_hi_reg;
        held_min_reg <= min_reg;
      end
    end
  end

  always_comb begin
    bus.running  = counting;
    bus.frozen   = (state_reg == HOLD);
    bus.tick     = tick_int;
    bus.overflow = overflow_reg;
    if (state_reg == HOLD) begin
      bus.sec_lo = held_lo_reg;
      bus.sec_hi = held_hi_reg;
      bus.min    = held_min_reg;
    end else begin
      bus.sec_lo = sec_lo_reg;
      bus.sec_hi = sec_hi_reg;
      bus.min    = min_reg;
    end
  end

endmodule
